// File: rtl/mlkem_pwm_sequencer.sv
// ML-KEM pairwise-multiply sequencer.
// Walks NUM_PAIRS coefficient pairs. For each pair it issues reads of A, B
// (or takes a sampler word) and optionally the old destination word W. It
// presents the operands to an external pairwise multiplier, then writes the
// multiplier result back to the destination once the result has settled.

package mlkem_pwm_pkg;

  // Operand bundle handed to the pairwise multiplier (zeta travels separately).
  typedef struct packed {
    logic [11:0] u1;
    logic [11:0] u0;
    logic [11:0] v1;
    logic [11:0] v0;
    logic [11:0] w1;
    logic [11:0] w0;
  } mlkem_pwo_uvwzi_t;

  // Result pair returned by the pairwise multiplier.
  typedef struct packed {
    logic [11:0] uv1_o;
    logic [11:0] uv0_o;
  } mlkem_pwo_t;

endpackage

module mlkem_pwm_sequencer
  import mlkem_pwm_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int NUM_PAIRS = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zeroize,
  input  logic                  start_i,
  input  logic                  accumulate_i,
  input  logic                  sampler_mode_i,
  input  logic [ADDR_W-1:0]     a_base_i,
  input  logic [ADDR_W-1:0]     b_base_i,
  input  logic [ADDR_W-1:0]     dst_base_i,
  output logic                  a_rd_en_o,
  output logic [ADDR_W-1:0]     a_rd_addr_o,
  output logic                  b_rd_en_o,
  output logic [ADDR_W-1:0]     b_rd_addr_o,
  output logic                  w_rd_en_o,
  output logic [ADDR_W-1:0]     w_rd_addr_o,
  input  logic [23:0]           a_rd_data_i,
  input  logic [23:0]           b_rd_data_i,
  input  logic [23:0]           w_rd_data_i,
  input  logic                  sampler_valid_i,
  input  logic [23:0]           sampler_data_i,
  output logic                  sampler_ready_o,
  output logic [6:0]            zeta_addr_o,
  input  logic [11:0]           zeta_i,
  output mlkem_pwo_uvwzi_t      pwo_uvw_o,
  output logic [11:0]           pwo_z_o,
  output logic                  accumulate_o,
  input  mlkem_pwo_t            pwo_uv_i,
  output logic                  wr_en_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [23:0]           wr_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  // Delay line after the operand cycle. The multiplier result is ready
  // 4 cycles after the operands (5 when accumulating), so the write taps
  // the line at stage 3 or stage 4.
  localparam int DLY_N     = 5;
  localparam int TAP_PLAIN = 3;
  localparam int TAP_ACC   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Reset and zeroize have identical effect.
  logic clr;
  assign clr = reset | zeroize;

  // Configuration latched at start.
  logic              acc_q;
  logic              smode_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic [ADDR_W-1:0] dst_base_q;

  // Pair index of the next issue.
  logic [IDX_W-1:0]  idx_q;

  // Issue stage (combinational, _p0).
  logic              issue_p0;
  logic [ADDR_W-1:0] dst_addr_p0;

  // Operand stage (_p1): read data arrives this cycle.
  logic              vld_p1;
  logic [ADDR_W-1:0] dst_addr_p1;
  logic [23:0]       samp_p1;

  // Tag and destination-address delay line behind the operand stage.
  logic [DLY_N-1:0]  vld_dly;
  logic [ADDR_W-1:0] dst_dly [DLY_N];

  logic              pipe_busy;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_dst;

  // Base plus pair index, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base,
                                                input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

  assign dst_addr_p0 = addr_at(dst_base_q, idx_q);
  assign pipe_busy   = vld_p1 | (|vld_dly);

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave RUN on the last issue, finish once the line drains.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (issue_p0 && (idx_q == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:   if (!pipe_busy) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs and the per-cycle issue decision.
  always_comb begin
    busy_o          = 1'b0;
    done_o          = 1'b0;
    sampler_ready_o = 1'b0;
    accumulate_o    = 1'b0;
    issue_p0        = 1'b0;
    case (state)
      RUN: begin
        busy_o          = 1'b1;
        accumulate_o    = acc_q;
        sampler_ready_o = smode_q;
        issue_p0        = !smode_q || sampler_valid_i;
      end
      DRAIN: begin
        busy_o       = 1'b1;
        accumulate_o = acc_q;
      end
      DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        accumulate_o = acc_q;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Latch configuration on an accepted start; advance the index per issue.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_q      <= 1'b0;
      smode_q    <= 1'b0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      dst_base_q <= '0;
      idx_q      <= '0;
    end else if ((state == IDLE) && start_i) begin
      acc_q      <= accumulate_i;
      smode_q    <= sampler_mode_i;
      a_base_q   <= a_base_i;
      b_base_q   <= b_base_i;
      dst_base_q <= dst_base_i;
      idx_q      <= '0;
    end else if (issue_p0) begin
      idx_q      <= idx_q + 1'b1;
    end
  end

  // Read ports and zeta index, driven only in an issue cycle.
  always_comb begin
    a_rd_en_o   = 1'b0;
    a_rd_addr_o = '0;
    b_rd_en_o   = 1'b0;
    b_rd_addr_o = '0;
    w_rd_en_o   = 1'b0;
    w_rd_addr_o = '0;
    zeta_addr_o = '0;
    if (issue_p0) begin
      a_rd_en_o   = 1'b1;
      a_rd_addr_o = addr_at(a_base_q, idx_q);
      b_rd_en_o   = !smode_q;
      b_rd_addr_o = addr_at(b_base_q, idx_q);
      w_rd_en_o   = acc_q;
      w_rd_addr_o = dst_addr_p0;
      zeta_addr_o = 7'(idx_q);
    end
  end

  // ---- stage p0 -> p1: capture issue tag, destination and sampler word ----
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1      <= 1'b0;
      dst_addr_p1 <= '0;
      samp_p1     <= '0;
    end else begin
      vld_p1 <= issue_p0;
      if (issue_p0) begin
        dst_addr_p1 <= dst_addr_p0;
      end
      if (issue_p0 && smode_q) begin
        samp_p1 <= sampler_data_i;
      end
    end
  end

  // Operand presentation in the cycle after issue; quiet otherwise.
  always_comb begin
    pwo_uvw_o = '0;
    pwo_z_o   = '0;
    if (vld_p1) begin
      pwo_uvw_o.u0 = a_rd_data_i[11:0];
      pwo_uvw_o.u1 = a_rd_data_i[23:12];
      pwo_uvw_o.v0 = smode_q ? samp_p1[11:0]  : b_rd_data_i[11:0];
      pwo_uvw_o.v1 = smode_q ? samp_p1[23:12] : b_rd_data_i[23:12];
      pwo_uvw_o.w0 = acc_q ? w_rd_data_i[11:0]  : 12'd0;
      pwo_uvw_o.w1 = acc_q ? w_rd_data_i[23:12] : 12'd0;
      pwo_z_o      = zeta_i;
    end
  end

  // ---- stage p1 -> delay line: shift tags with their destination address ----
  // A tag consumed at the short tap is not carried into the last stage, so an
  // empty line always means no write is pending.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_dly <= '0;
      for (int k = 0; k < DLY_N; k++) begin
        dst_dly[k] <= '0;
      end
    end else begin
      vld_dly[0] <= vld_p1;
      dst_dly[0] <= dst_addr_p1;
      for (int k = 1; k < DLY_N; k++) begin
        vld_dly[k] <= vld_dly[k-1];
        dst_dly[k] <= dst_dly[k-1];
      end
      vld_dly[TAP_ACC] <= vld_dly[TAP_ACC-1] & acc_q;
    end
  end

  assign wr_fire = acc_q ? vld_dly[TAP_ACC] : vld_dly[TAP_PLAIN];
  assign wr_dst  = acc_q ? dst_dly[TAP_ACC] : dst_dly[TAP_PLAIN];

  // Destination write: multiplier result lands at the tagged address.
  always_comb begin
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (wr_fire) begin
      wr_en_o   = 1'b1;
      wr_addr_o = wr_dst;
      wr_data_o = {pwo_uv_i.uv1_o, pwo_uv_i.uv0_o};
    end
  end

endmodule

// File: doc/mlkem_pwm_sequencer.md
MLKEM_PWM_SEQUENCER -- requirements
Module: mlkem_pwm_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, memory word address width.
REQ-002 Parameter NUM_PAIRS, default 128, coefficient pairs per polynomial.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 zeroize  in  1  synchronous clear, same effect as reset.
REQ-006 start_i  in  1  one-cycle pulse; begin one polynomial pairwise multiply.
REQ-007 accumulate_i  in  1  sampled at start; add previous destination contents.
REQ-008 sampler_mode_i  in  1  sampled at start; B operand from sampler stream, else from memory.
REQ-009 a_base_i, b_base_i, dst_base_i  in  ADDR_W each  base addresses, sampled at start.
REQ-010 a_rd_en_o, a_rd_addr_o  out  1, ADDR_W  A read port.
REQ-011 b_rd_en_o, b_rd_addr_o  out  1, ADDR_W  B read port.
REQ-012 w_rd_en_o, w_rd_addr_o  out  1, ADDR_W  accumulate read port.
REQ-013 a_rd_data_i, b_rd_data_i, w_rd_data_i  in  24 each  {coef1[23:12], coef0[11:0]}; 1-cycle read latency.
REQ-014 sampler_valid_i  in  1 / sampler_data_i  in  24 / sampler_ready_o  out  1  sampler stream handshake.
REQ-015 zeta_addr_o  out  7  zeta ROM index; zeta_i  in  12, 1-cycle ROM latency.
REQ-016 pwo_uvw_o  out  mlkem_pwo_uvwzi_t / pwo_z_o  out  12 / accumulate_o  out  1  to pairwise multiplier.
REQ-017 pwo_uv_i  in  mlkem_pwo_t  multiplier results.
REQ-018 wr_en_o, wr_addr_o, wr_data_o  out  1, ADDR_W, 24  destination write port.
REQ-019 busy_o  out  1 / done_o  out  1  status.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; start_i in IDLE -> RUN and latches config; start_i outside IDLE ignored.
REQ-021 RUN: issue occurs in a cycle iff !sampler_mode or sampler_valid_i; sampler_ready_o = (state==RUN) && sampler_mode.
REQ-022 Issue of index i (0..NUM_PAIRS-1): a_rd_en_o=1, a_rd_addr_o=a_base+i; b_rd_en_o=!sampler_mode, b_rd_addr_o=b_base+i; w_rd_en_o=accumulate, w_rd_addr_o=dst_base+i; zeta_addr_o=i; sampler_data_i captured if sampler_mode.
REQ-023 Address addition modulo 2^ADDR_W (wrap-around, no error).
REQ-024 Cycle after issue: pwo_uvw_o.u0/u1 from a_rd_data_i, v0/v1 from b_rd_data_i or captured sampler word, w0/w1 from w_rd_data_i (zero when !accumulate); pwo_z_o = zeta_i.
REQ-025 Operand-valid tag enters a delay line; write fires L cycles after operand cycle, L=4 (accumulate=0) or 5 (accumulate=1).
REQ-026 Write: wr_en_o=1, wr_addr_o=dst_base+i, wr_data_o={pwo_uv_i.uv1_o, pwo_uv_i.uv0_o}; addresses carried in the delay line with the tag.
REQ-027 Sampler stall: no issue, no read enables, no tag; in-flight tags still advance; order of writes equals issue order.
REQ-028 After issue of index NUM_PAIRS-1: RUN -> DRAIN; DRAIN -> DONE when delay line empty; DONE -> IDLE next cycle.
REQ-029 done_o high exactly one cycle (state DONE); busy_o high in RUN, DRAIN, DONE.
REQ-030 accumulate_o equals latched accumulate throughout RUN/DRAIN/DONE; 0 in IDLE.
REQ-031 Exactly NUM_PAIRS reads of each enabled port and NUM_PAIRS writes per operation; sampler handshake consumes exactly NUM_PAIRS words.
REQ-032 Accumulate in place (w read of address X precedes write of X by L+1 cycles) is legal; no hazard logic required.

Reset
REQ-033 reset or zeroize: state IDLE, index 0, delay line and captured data cleared, all enables/ready/done/busy/accumulate_o 0, addresses and data outputs 0.
REQ-034 reset/zeroize mid-RUN or mid-DRAIN: no further writes issued, including in-flight tags.

Verification
REQ-035 start, sampler_mode=0, accumulate=0, a_base=0, b_base=128, dst_base=256 -> 128 consecutive issues, first write to 256 exactly 5 cycles after first issue, done_o pulse after last write.
REQ-036 accumulate=1, same bases -> w reads at 256..383, first write 6 cycles after first issue, wr_data equals model (a*b + w) mod 3329.
REQ-037 sampler_mode=1, sampler_valid toggling 1,0,0,1... -> issues only on valid cycles, b_rd_en_o never asserted, write addresses contiguous with gaps matching stalls.
REQ-038 a_base=1020, ADDR_W=10 -> a_rd_addr sequence 1020..1023,0..123.
REQ-039 reset asserted at pair 60 in RUN -> next cycle all outputs 0, no writes afterward; new start runs full 128 pairs.
REQ-040 start_i pulsed during RUN and DRAIN -> ignored; single done_o; busy_o deasserts cycle after DONE.
